// File: rtl/gamma_cycle_encoder.sv
// Gamma-cycle temporal encoder: maps intensities to spike times and runs
// the per-cycle time counter, with one shadow vector buffered ahead.
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 3
`endif

module gamma_cycle_encoder #(
    parameter int N_INPUTS    = 8,
    parameter int INTENSITY_W = 8,
    parameter int NULL_THRESH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [N_INPUTS*INTENSITY_W-1:0]        in_intensity,
    input  logic                                   pause,
    output logic [`LOG_TIME_PERIOD:0]              time_val,
    output logic [N_INPUTS*`LOG_TIME_PERIOD-1:0]   spike_time,
    output logic [N_INPUTS-1:0]                    should_spike,
    output logic                                   cycle_active,
    output logic                                   cycle_done
);

    localparam int L = `LOG_TIME_PERIOD;
    localparam int W = INTENSITY_W;
    localparam int N = N_INPUTS;

    localparam logic [L:0] TP_V  = {1'b1, {L{1'b0}}};
    localparam logic [W:0] THR_V = NULL_THRESH[W:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [L:0]     time_q, time_d;
    logic           shadow_full_q, shadow_full_d;
    logic [N*L-1:0] shadow_st_q;
    logic [N-1:0]   shadow_ss_q;
    logic [N*L-1:0] act_st_q;
    logic [N-1:0]   act_ss_q;

    logic [N*L-1:0] enc_st;
    logic [N-1:0]   enc_ss;
    logic [W-1:0]   inv;
    logic [W-1:0]   ch;
    logic           accept;
    logic           load;

    // Brighter channels get a smaller inverted value, hence an earlier spike.
    always_comb begin
        enc_st = '0;
        enc_ss = '0;
        inv    = '0;
        ch     = '0;
        for (int i = 0; i < N; i++) begin
            ch                = in_intensity[i*W +: W];
            inv               = ~ch;
            enc_st[i*L +: L]  = inv[W-1 -: L];
            enc_ss[i]         = ({1'b0, ch} < THR_V);
        end
    end

    assign accept = in_valid & ~shadow_full_q;

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                time_d = '0;
                if (shadow_full_q) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!pause) begin
                    if (time_q == TP_V) begin
                        state_d = S_DONE;
                    end else begin
                        time_d = time_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                time_d = '0;
                if (shadow_full_q) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                time_d  = '0;
            end
        endcase
    end

    // Accept and load are exclusive since accept requires an empty shadow.
    always_comb begin
        shadow_full_d = shadow_full_q;
        if (accept) begin
            shadow_full_d = 1'b1;
        end else if (load) begin
            shadow_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            time_q        <= '0;
            shadow_full_q <= 1'b0;
            shadow_st_q   <= '0;
            shadow_ss_q   <= '1;
            act_st_q      <= '0;
            act_ss_q      <= '1;
        end else begin
            state_q       <= state_d;
            time_q        <= time_d;
            shadow_full_q <= shadow_full_d;
            if (accept) begin
                shadow_st_q <= enc_st;
                shadow_ss_q <= enc_ss;
            end
            if (load) begin
                act_st_q <= shadow_st_q;
                act_ss_q <= shadow_ss_q;
            end
        end
    end

    assign in_ready     = ~shadow_full_q;
    assign time_val     = time_q;
    assign spike_time   = act_st_q;
    assign cycle_active = (state_q == S_RUN);
    assign cycle_done   = (state_q == S_DONE);
    assign should_spike = (state_q == S_RUN) ? act_ss_q : '1;

endmodule

// File: doc/gamma_cycle_encoder.md
# gamma_cycle_encoder

Front end of the clocked temporal-coding pipeline. It accepts intensity vectors over a ready/valid handshake and converts each channel into a spike time, with brighter channels spiking earlier. It runs the gamma-cycle time counter and drives the `time_val`, `spike_time` and `should_spike` buses consumed by the per-channel spike generation stage. One vector is double-buffered, so the next input can be accepted while the current gamma cycle runs.

## Interface
Widths use `` `log_time_period `` from `internal_defines.vh`. TP = 2**`` `log_time_period ``.

Parameters:
- `N_INPUTS`, 8: number of channels.
- `INTENSITY_W`, 8: bits per intensity. Must be ≥ `` `log_time_period ``.
- `NULL_THRESH`, 16: intensities below this value produce no spike.

Ports:
- `clk` in 1: sole clock. All state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: intensity vector valid.
- `in_ready` out 1: encoder can accept a vector.
- `in_intensity` in N_INPUTS*INTENSITY_W: packed intensities. Channel i is at `[i*INTENSITY_W +: INTENSITY_W]`.
- `pause` in 1: freezes the time counter while in RUN.
- `time_val` out `` `log_time_period ``+1: current gamma-cycle time.
- `spike_time` out N_INPUTS*`` `log_time_period ``: packed per-channel spike times.
- `should_spike` out N_INPUTS: per-channel enable. 0 = channel may spike, 1 = channel suppressed.
- `cycle_active` out 1: high in RUN.
- `cycle_done` out 1: one-cycle pulse in DONE.

## Operation
- Per-channel encoding is applied when a vector is accepted:
  - inv = (2**INTENSITY_W − 1) − intensity.
  - spike_time = inv[INTENSITY_W−1 -: `` `log_time_period ``] (top bits, truncating).
  - should_spike = 1 if intensity < NULL_THRESH, else 0.
- The encoded result is stored in the shadow register. `shadow_full` is set on accept.
- `in_ready` = !shadow_full (registered flag, combinational output).
- State machine, with active registers driving the outputs:
  - IDLE:
    - `should_spike` = all 1, `time_val` = 0.
    - If shadow_full: copy shadow to the active registers, clear shadow_full, set `time_val` = 0, go to RUN.
  - RUN:
    - `cycle_active` = 1.
    - `time_val` increments by 1 per cycle unless `pause` = 1, in which case it holds.
    - When `time_val` = TP and `pause` = 0, go to DONE.
  - DONE:
    - `cycle_done` = 1, `cycle_active` = 0, `should_spike` forced to all 1, `time_val` holds TP.
    - Next state: if shadow_full, load shadow and go to RUN with `time_val` = 0; else go to IDLE with `time_val` = 0.
- `time_val` never exceeds TP. The extra bit exists only to represent TP.
- Accept and transfer never happen in the same cycle, because `in_ready` is 0 whenever shadow_full = 1.
- `in_intensity` is sampled only on the accept edge (`in_valid` & `in_ready`).
- `pause` in IDLE or DONE has no effect.
- Reset mid-cycle:
  - Returns to IDLE and clears shadow_full and the active registers immediately.
  - An in-flight gamma cycle is discarded with no `cycle_done` pulse.

## Timing
- Reset values:
  - state IDLE; shadow_full 0; `in_ready` 1.
  - `time_val` 0; `spike_time` all 0; `should_spike` all 1.
  - `cycle_active` 0; `cycle_done` 0.
- Latency from an accept at edge k, with the encoder in IDLE:
  - Edge k+1 enters RUN with `time_val` = 0.
  - `time_val` = j during cycle k+1+j, for j = 0..TP (no pause).
  - DONE occurs in cycle k+TP+2.
- RUN lasts TP+1 cycles plus one per paused cycle. DONE lasts exactly 1 cycle.
- Back-to-back vectors: consecutive gamma cycles are separated by exactly one DONE cycle. Throughput is one vector per TP+2 cycles.
- `in_ready` rises in the cycle after the shadow is transferred.

## Test plan
Configuration for all scenarios: `` `log_time_period `` = 3 (TP = 8), INTENSITY_W = 8, N_INPUTS = 4, NULL_THRESH = 16.

- **Reset:** hold `rst_n` = 0 → `in_ready` = 1, `time_val` = 0, `should_spike` = 4'b1111, `cycle_active` = 0, `cycle_done` = 0. Assert reset asynchronously mid-RUN → all outputs return to these values without waiting for a clock edge.
- **Encoding:** intensities {255, 100, 16, 15} accepted → `spike_time` = {0, 4, 7, 7}, `should_spike` = {0, 0, 0, 1}.
- **Single cycle:** accept at edge k → `cycle_active` is high for 9 cycles with `time_val` 0..8, `cycle_done` is high in cycle k+10, then IDLE with `time_val` = 0.
- **Double buffer:** second vector offered during RUN → accepted at once and `in_ready` goes 0. The following DONE is followed directly by RUN carrying the new spike times. A third vector offered is stalled until the second transfer completes.
- **Pause:** hold `pause` = 1 for 3 cycles at `time_val` = 5 → `time_val` stays 5, RUN lasts 12 cycles, `cycle_done` is delayed by 3.
- **Idle suppression:** no input offered → `should_spike` stays all 1 and `cycle_done` never pulses.
